// File: rtl/cfu_pim_mac_pkg.sv
// Shared opcode and FSM encodings plus default sizing for the PIM multiply-accumulate CFU.
package cfu_pim_pkg;

  localparam int DWIDTH_DEF = 32;
  localparam int PWIDTH_DEF = 32;
  localparam int AWIDTH_DEF = 4;
  localparam int ABITS_DEF  = 8;

  typedef enum logic [2:0] {
    OP_WRITE  = 3'd0,
    OP_READ   = 3'd1,
    OP_LDACT  = 3'd2,
    OP_MAC    = 3'd3,
    OP_CLRACT = 3'd4
  } opcode_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPUTE,
    S_RESP
  } state_e;

endpackage

// File: rtl/cfu_pim_mac_if.sv
// CFU command/response bus; the master drives commands, the slave returns responses.
interface cfu_pim_mac_if
  import cfu_pim_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic [9:0]        cmd_payload_function_id;
  logic [31:0]       cmd_payload_inputs_0;
  logic [31:0]       cmd_payload_inputs_1;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DWIDTH-1:0] rsp_payload_outputs_0;
  logic              rsp_payload_response_ok;

  modport master (
    output cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0,
           cmd_payload_inputs_1, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_payload_outputs_0, rsp_payload_response_ok
  );

  modport slave (
    input  cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0,
           cmd_payload_inputs_1, rsp_ready,
    output cmd_ready, rsp_valid, rsp_payload_outputs_0, rsp_payload_response_ok
  );

endinterface

// File: rtl/cfu_pim_mac_col_adder.sv
// Column popcounts of the word-line-selected rows, weighted by column position into one partial sum.
module pim_col_adder #(
  parameter int PWIDTH = 32,
  parameter int DEPTH  = 16,
  parameter int DWIDTH = 32
) (
  input  logic [DEPTH-1:0]  rwl,
  input  logic [PWIDTH-1:0] mem [DEPTH],
  output logic [DWIDTH-1:0] p
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0] adc [PWIDTH];

  always_comb begin
    p = '0;
    for (int unsigned i = 0; i < PWIDTH; i++) begin
      adc[i] = '0;
      for (int unsigned j = 0; j < DEPTH; j++) begin
        adc[i] = adc[i] + CW'(rwl[j] & mem[j][i]);
      end
      p = p + (DWIDTH'(adc[i]) << i);
    end
  end

endmodule

// File: rtl/cfu_pim_mac.sv
// Processing-in-memory MAC CFU: row memory plus per-row activations, dot product computed bit-serially over activation bits.
module cfu_pim_mac
  import cfu_pim_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int PWIDTH = PWIDTH_DEF,
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int ABITS  = ABITS_DEF
) (
  input  logic         clk,
  input  logic         reset,
  cfu_pim_mac_if.slave bus
);

  localparam int DEPTH = 2 ** AWIDTH;
  localparam int KW    = (ABITS > 1) ? $clog2(ABITS) : 1;

  state_e state, state_nxt;

  logic [2:0]        op;
  logic [AWIDTH-1:0] row;
  logic              cmd_fire;
  logic              last_step;

  // mem is deliberately outside the reset domain so its contents survive reset
  logic [PWIDTH-1:0] mem [DEPTH] = '{default: '0};
  logic [ABITS-1:0]  act [DEPTH];

  logic [DEPTH-1:0]  rwl;
  logic [DWIDTH-1:0] p;
  logic [DWIDTH-1:0] acc;
  logic [DWIDTH-1:0] acc_nxt;
  logic [DWIDTH-1:0] out_q;
  logic              ok_q;
  logic [KW-1:0]     k;

  logic unused_bits;
  assign unused_bits = ^{bus.cmd_payload_function_id[9:3], bus.cmd_payload_inputs_1[31:AWIDTH]};

  assign op        = bus.cmd_payload_function_id[2:0];
  assign row       = bus.cmd_payload_inputs_1[AWIDTH-1:0];
  assign cmd_fire  = bus.cmd_valid && bus.cmd_ready;
  assign last_step = (k == KW'(ABITS - 1));
  assign acc_nxt   = acc + (p << k);

  assign bus.cmd_ready               = reset && (state == S_IDLE);
  assign bus.rsp_valid               = (state == S_RESP);
  assign bus.rsp_payload_outputs_0   = out_q;
  assign bus.rsp_payload_response_ok = ok_q;

  always_comb begin
    rwl = '0;
    for (int unsigned j = 0; j < DEPTH; j++) begin
      rwl[j] = act[j][k];
    end
  end

  pim_col_adder #(
    .PWIDTH(PWIDTH),
    .DEPTH (DEPTH),
    .DWIDTH(DWIDTH)
  ) u_col_adder (
    .rwl(rwl),
    .mem(mem),
    .p  (p)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (cmd_fire) state_nxt = (op == OP_MAC) ? S_COMPUTE : S_RESP;
      S_COMPUTE: if (last_step) state_nxt = S_RESP;
      S_RESP:    if (bus.rsp_ready) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (cmd_fire && op == OP_WRITE) mem[row] <= bus.cmd_payload_inputs_0[PWIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc   <= '0;
      k     <= '0;
      out_q <= '0;
      ok_q  <= 1'b1;
      for (int unsigned j = 0; j < DEPTH; j++) act[j] <= '0;
    end else begin
      if (cmd_fire) begin
        ok_q  <= 1'b1;
        out_q <= '0;
        case (op)
          OP_WRITE:  out_q <= DWIDTH'(bus.cmd_payload_inputs_0[PWIDTH-1:0]);
          OP_READ:   out_q <= DWIDTH'(mem[row]);
          OP_LDACT:  act[row] <= bus.cmd_payload_inputs_0[ABITS-1:0];
          OP_MAC: begin
            acc <= '0;
            k   <= '0;
          end
          OP_CLRACT: for (int unsigned j = 0; j < DEPTH; j++) act[j] <= '0;
          default:   ok_q <= 1'b0;
        endcase
      end else if (state == S_COMPUTE) begin
        // final step bypasses acc so the full sum lands in out_q on the same edge
        acc <= acc_nxt;
        k   <= k + 1'b1;
        if (last_step) out_q <= acc_nxt;
      end
    end
  end

endmodule

// File: tb/tb_cfu_pim_mac.sv
// Randomized self-checking bench for cfu_pim_mac against an arithmetic dot-product reference.
module tb_cfu_pim_mac;
  import cfu_pim_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  cfu_pim_mac_if #(.DWIDTH(32)) bus ();

  cfu_pim_mac #(
    .DWIDTH(32),
    .PWIDTH(32),
    .AWIDTH(4),
    .ABITS (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem_m [16];
  logic [7:0]  act_m [16];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [2:0] op, input logic [31:0] d, input logic [31:0] r,
                       output logic [31:0] res, output logic ok);
    logic [3:0]  ri;
    logic [63:0] s;
    ri  = r[3:0];
    res = '0;
    ok  = 1'b1;
    case (op)
      3'd0: begin mem_m[ri] = d; res = d; end
      3'd1: res = mem_m[ri];
      3'd2: act_m[ri] = d[7:0];
      3'd3: begin
        s = '0;
        for (int j = 0; j < 16; j++) s = s + 64'(act_m[j]) * 64'(mem_m[j]);
        res = s[31:0];
      end
      3'd4: for (int j = 0; j < 16; j++) act_m[j] = '0;
      default: ok = 1'b0;
    endcase
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] d, input logic [31:0] r);
    int guard;
    guard = 0;
    bus.cmd_payload_function_id = {7'($urandom), op};
    bus.cmd_payload_inputs_0    = d;
    bus.cmd_payload_inputs_1    = r;
    bus.cmd_valid               = 1'b1;
    while (!bus.cmd_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) chk("accept_timeout", 64'(bus.cmd_ready), 64'd1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output logic [31:0] res, output logic ok, output int lat);
    lat = 1;
    while (!bus.rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.rsp_valid) chk("rsp_timeout", 64'(bus.rsp_valid), 64'd1);
    res = bus.rsp_payload_outputs_0;
    ok  = bus.rsp_payload_response_ok;
  endtask

  task automatic ack();
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic run(input logic [2:0] op, input logic [31:0] d, input logic [31:0] r,
                     input string tag, output logic [31:0] res);
    logic [31:0] er;
    logic        eok, ok;
    int          lat;
    issue(op, d, r);
    wait_rsp(res, ok, lat);
    model(op, d, r, er, eok);
    chk({tag, "_data"}, 64'(res), 64'(er));
    chk({tag, "_ok"}, 64'(ok), 64'(eok));
    chk({tag, "_lat"}, 64'(lat), (op == 3'd3) ? 64'd9 : 64'd1);
    ack();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] res, er;
    logic        ok, eok;
    int          lat, acc_n;
    logic [2:0]  op;

    bus.cmd_valid               = 1'b0;
    bus.cmd_payload_function_id = '0;
    bus.cmd_payload_inputs_0    = '0;
    bus.cmd_payload_inputs_1    = '0;
    bus.rsp_ready               = 1'b0;
    for (int j = 0; j < 16; j++) begin
      mem_m[j] = '0;
      act_m[j] = '0;
    end

    repeat (3) @(posedge clk);
    #1;
    chk("reset_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("reset_ok", 64'(bus.rsp_payload_response_ok), 64'd1);
    chk("reset_out", 64'(bus.rsp_payload_outputs_0), 64'd0);
    reset = 1'b1;
    #1;
    chk("release_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    @(posedge clk); #1;

    run(3'd0, 32'hDEADBEEF, 32'd3, "wr3", res);
    chk("wr3_const", 64'(res), 64'hDEADBEEF);
    run(3'd1, 32'h0, 32'd3, "rd3", res);
    chk("rd3_const", 64'(res), 64'hDEADBEEF);

    run(3'd2, 32'd5, 32'd0, "ld0", res);
    run(3'd2, 32'd3, 32'd1, "ld1", res);
    run(3'd0, 32'd7, 32'd0, "wr0", res);
    run(3'd0, 32'd10, 32'd1, "wr1", res);
    run(3'd3, 32'd0, 32'd0, "mac65", res);
    chk("mac65_const", 64'(res), 64'd65);

    run(3'd0, 32'h0BADF00D, 32'd16, "wr_wrap", res);
    run(3'd1, 32'h0, 32'd0, "rd_wrap", res);
    chk("rd_wrap_const", 64'(res), 64'h0BADF00D);

    run(3'd6, 32'h12345678, 32'd3, "illegal", res);
    run(3'd1, 32'h0, 32'd3, "rd_after_ill", res);
    chk("rd_after_ill_const", 64'(res), 64'hDEADBEEF);

    for (int j = 0; j < 16; j++) begin
      run(3'd2, 32'd255, 32'(j), "ld_full", res);
      run(3'd0, 32'hFFFFFFFF, 32'(j), "wr_full", res);
    end
    run(3'd3, 32'd0, 32'd0, "mac_full", res);
    chk("mac_full_const", 64'(res), 64'hFFFFF010);

    run(3'd0, 32'h00A5A5A5, 32'd2, "wr2", res);
    issue(3'd3, 32'd0, 32'd0);
    wait_rsp(res, ok, lat);
    model(3'd3, 32'd0, 32'd0, er, eok);
    chk("hold_lat", 64'(lat), 64'd9);
    chk("hold_first", 64'(res), 64'(er));
    for (int i = 0; i < 5; i++) begin
      bus.cmd_payload_function_id = 10'd0;
      bus.cmd_payload_inputs_0    = 32'h12345678;
      bus.cmd_payload_inputs_1    = 32'd2;
      bus.cmd_valid               = (i % 2 == 0);
      @(posedge clk); #1;
      chk("hold_valid", 64'(bus.rsp_valid), 64'd1);
      chk("hold_data", 64'(bus.rsp_payload_outputs_0), 64'(er));
      chk("hold_ready", 64'(bus.cmd_ready), 64'd0);
    end
    bus.cmd_valid = 1'b0;
    ack();
    run(3'd1, 32'h0, 32'd2, "rd_after_hold", res);

    issue(3'd3, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("abort_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("abort_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    chk("abort_out", 64'(bus.rsp_payload_outputs_0), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("abort_hold_valid", 64'(bus.rsp_valid), 64'd0);
    reset = 1'b1;
    #1;
    chk("abort_release_ready", 64'(bus.cmd_ready), 64'd1);
    for (int j = 0; j < 16; j++) act_m[j] = '0;
    @(posedge clk); #1;
    run(3'd3, 32'd0, 32'd0, "mac_after_rst", res);
    chk("mac_after_rst_const", 64'(res), 64'd0);
    run(3'd1, 32'h0, 32'd5, "rd_kept", res);
    chk("rd_kept_const", 64'(res), 64'hFFFFFFFF);

    bus.rsp_ready               = 1'b1;
    bus.cmd_payload_function_id = 10'd1;
    bus.cmd_payload_inputs_1    = 32'd0;
    bus.cmd_valid               = 1'b1;
    acc_n = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.cmd_ready) acc_n++;
      @(posedge clk); #1;
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    chk("b2b_accepts", 64'(acc_n), 64'd4);

    repeat (150) begin
      op = 3'($urandom_range(0, 7));
      run(op, $urandom, $urandom, "rand", res);
    end
    run(3'd3, 32'd0, 32'd0, "rand_final_mac", res);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
